// File: rtl/mpu_region_guard.sv
// ---------------------------------------------------------------------------------------------
// mpu_region_guard
//
// Registered memory-protection guard placed between the processor request path and memory.
// Every valid request is compared against NUM_REGIONS programmable inclusive address windows.
// A blocked request is forwarded as address 0 with resp_protected raised; the response appears
// one cycle after the request is sampled.
//
// Access policy is held in a three-state FSM:
//   StLocked  - requests hitting an enabled window are blocked unless i_trigger bypasses them.
//   StSession - opened or refreshed by i_login, closes after SESSION_LEN idle cycles; nothing is
//               blocked and the region table may be rewritten.
//   StLockout - entered once the fault counter reaches MAX_FAULTS; everything is blocked and only
//               reset leaves this state.
//
// Optional feature (macro MPU_FAULT_ADDR_EN): records the address of the first blocked request
// after reset on o_fault_addr / o_fault_addr_valid.
//
// Ports:
//   i_clock            system clock, rising edge
//   i_reset            asynchronous reset, active low
//   i_login            open or refresh a session
//   i_trigger          per-request bypass, sampled with i_req_valid (ignored in lockout)
//   i_cfg_wr_en        region table write strobe (honoured only in a session)
//   i_cfg_idx          region to write; indexes >= NUM_REGIONS are dropped
//   i_cfg_base         new inclusive lower bound
//   i_cfg_limit        new inclusive upper bound
//   i_cfg_enable       new region enable
//   i_req_valid        request present
//   i_req_addr         processor address
//   o_resp_valid       response present (follows i_req_valid one cycle later)
//   o_resp_addr        address to memory, 0 when blocked or idle
//   o_resp_protected   request was blocked
//   o_resp_region      lowest matching region index, 0 if none or idle
//   o_session_active   FSM is in StSession
//   o_lockout          FSM is in StLockout
//   o_fault_count      saturating count of blocked requests
//   o_fault_addr       (MPU_FAULT_ADDR_EN) first blocked address since reset
//   o_fault_addr_valid (MPU_FAULT_ADDR_EN) o_fault_addr holds a captured address
// ---------------------------------------------------------------------------------------------

module mpu_region_guard #(
    parameter int unsigned     ADDR_W      = 64,
    parameter int unsigned     NUM_REGIONS = 4,
    parameter int unsigned     IDX_W       = 2,
    parameter longint unsigned DEF_LOWER   = 8000,
    parameter longint unsigned DEF_UPPER   = 8800,
    parameter int unsigned     SESSION_LEN = 16,
    parameter int unsigned     CNT_W       = 8,
    parameter int unsigned     MAX_FAULTS  = 4
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_login,
    input  logic              i_trigger,
    input  logic              i_cfg_wr_en,
    input  logic [IDX_W-1:0]  i_cfg_idx,
    input  logic [ADDR_W-1:0] i_cfg_base,
    input  logic [ADDR_W-1:0] i_cfg_limit,
    input  logic              i_cfg_enable,
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              o_resp_valid,
    output logic [ADDR_W-1:0] o_resp_addr,
    output logic              o_resp_protected,
    output logic [IDX_W-1:0]  o_resp_region,
    output logic              o_session_active,
    output logic              o_lockout,
    output logic [CNT_W-1:0]  o_fault_count
`ifdef MPU_FAULT_ADDR_EN
    ,
    output logic [ADDR_W-1:0] o_fault_addr,
    output logic              o_fault_addr_valid
`endif
);

    // Wide enough to hold SESSION_LEN itself.
    localparam int unsigned TMR_W = $clog2(SESSION_LEN + 1);

    typedef enum logic [1:0] {
        StLocked,
        StSession,
        StLockout
    } state_e;

    // -----------------------------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------------------------
    state_e              r_state;
    state_e              w_state_d;
    logic [TMR_W-1:0]    r_timer;
    logic [TMR_W-1:0]    w_timer_d;

    logic [ADDR_W-1:0]   r_base  [NUM_REGIONS];
    logic [ADDR_W-1:0]   r_limit [NUM_REGIONS];
    logic                r_en    [NUM_REGIONS];

    logic [NUM_REGIONS-1:0] w_match;
    logic                   w_any_match;
    logic [IDX_W-1:0]       w_hit_idx;
    logic                   w_block;
    logic                   w_fault_limit;
    logic                   w_cfg_idx_ok;
    logic                   w_cfg_write;

    logic                r_resp_valid;
    logic [ADDR_W-1:0]   r_resp_addr;
    logic                r_resp_protected;
    logic [IDX_W-1:0]    r_resp_region;
    logic [CNT_W-1:0]    r_fault_count;

    // -----------------------------------------------------------------------------------------
    // Region match and block decision (uses state and table from before the current edge)
    // -----------------------------------------------------------------------------------------
    always_comb begin
        w_match = '0;
        for (int i = 0; i < int'(NUM_REGIONS); i++) begin
            // A window with base > limit can never satisfy both compares.
            w_match[i] = r_en[i] && (i_req_addr >= r_base[i]) && (i_req_addr <= r_limit[i]);
        end
    end

    assign w_any_match = |w_match;

    // Walk downwards so the lowest matching index wins.
    always_comb begin
        w_hit_idx = '0;
        for (int i = int'(NUM_REGIONS) - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_block = 1'b0;
        if (r_state == StLockout) begin
            w_block = 1'b1;
        end else if (r_state == StLocked && !i_trigger) begin
            w_block = w_any_match;
        end
    end

    // Lockout is taken on the cycle in which the registered count already shows the limit.
    assign w_fault_limit = (r_fault_count >= CNT_W'(MAX_FAULTS));

    // -----------------------------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= StLocked;
            r_timer <= '0;
        end else begin
            r_state <= w_state_d;
            r_timer <= w_timer_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StLocked: begin
                if (w_fault_limit) begin
                    w_state_d = StLockout;
                end else if (i_login) begin
                    w_state_d = StSession;
                end
            end
            StSession: begin
                if (w_fault_limit) begin
                    w_state_d = StLockout;
                end else if (!i_login && r_timer == TMR_W'(1)) begin
                    w_state_d = StLocked;
                end
            end
            StLockout: begin
                w_state_d = StLockout;
            end
            default: begin
                // Unreachable encoding: fail secure.
                w_state_d = StLockout;
            end
        endcase
    end

    // Timer is loaded on entry or login and counts down while the session stays open.
    always_comb begin
        w_timer_d = '0;
        if (w_state_d == StSession) begin
            if (r_state != StSession || i_login) begin
                w_timer_d = TMR_W'(SESSION_LEN);
            end else begin
                w_timer_d = r_timer - TMR_W'(1);
            end
        end
    end

    always_comb begin
        o_session_active = (r_state == StSession);
        o_lockout        = (r_state == StLockout);
    end

    // -----------------------------------------------------------------------------------------
    // Region table
    // -----------------------------------------------------------------------------------------
    assign w_cfg_idx_ok = (32'(i_cfg_idx) < NUM_REGIONS);
    assign w_cfg_write  = (r_state == StSession) && i_cfg_wr_en && w_cfg_idx_ok;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < int'(NUM_REGIONS); i++) begin
                r_base[i]  <= (i == 0) ? ADDR_W'(DEF_LOWER) : '0;
                r_limit[i] <= (i == 0) ? ADDR_W'(DEF_UPPER) : '0;
                r_en[i]    <= (i == 0);
            end
        end else if (w_cfg_write) begin
            r_base[i_cfg_idx]  <= i_cfg_base;
            r_limit[i_cfg_idx] <= i_cfg_limit;
            r_en[i_cfg_idx]    <= i_cfg_enable;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Response path and fault counter
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_resp_valid     <= 1'b0;
            r_resp_addr      <= '0;
            r_resp_protected <= 1'b0;
            r_resp_region    <= '0;
        end else begin
            r_resp_valid     <= i_req_valid;
            r_resp_addr      <= (i_req_valid && !w_block) ? i_req_addr : '0;
            r_resp_protected <= i_req_valid && w_block;
            r_resp_region    <= i_req_valid ? w_hit_idx : '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_fault_count <= '0;
        end else if (i_req_valid && w_block && (r_fault_count != '1)) begin
            r_fault_count <= r_fault_count + CNT_W'(1);
        end
    end

    assign o_resp_valid     = r_resp_valid;
    assign o_resp_addr      = r_resp_addr;
    assign o_resp_protected = r_resp_protected;
    assign o_resp_region    = r_resp_region;
    assign o_fault_count    = r_fault_count;

`ifdef MPU_FAULT_ADDR_EN
    // -----------------------------------------------------------------------------------------
    // First-fault address capture; later faults never overwrite it.
    // -----------------------------------------------------------------------------------------
    logic [ADDR_W-1:0] r_fault_addr;
    logic              r_fault_addr_valid;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_fault_addr       <= '0;
            r_fault_addr_valid <= 1'b0;
        end else if (!r_fault_addr_valid && i_req_valid && w_block) begin
            r_fault_addr       <= i_req_addr;
            r_fault_addr_valid <= 1'b1;
        end
    end

    assign o_fault_addr       = r_fault_addr;
    assign o_fault_addr_valid = r_fault_addr_valid;
`endif

endmodule

// File: doc/mpu_region_guard.md
Name: mpu_region_guard

Overview:
- Parametrised, registered successor to the single-window protection check.
- Compares each processor memory request against NUM_REGIONS programmable inclusive address windows.
- Blocked requests return a zero address and raise protected; the block is placed between the processor request path and memory.
- Adds a timed login session, a saturating fault counter and a sticky lockout state machine.

Parameters:
- ADDR_W, 64, address width.
- NUM_REGIONS, 4, number of protected windows (1..16).
- IDX_W, 2, width of region index; must equal ceil(log2(NUM_REGIONS)), minimum 1.
- DEF_LOWER, 8000, reset base of region 0.
- DEF_UPPER, 8800, reset limit of region 0.
- SESSION_LEN, 16, cycles a login session stays open (>=1).
- CNT_W, 8, fault counter width.
- MAX_FAULTS, 4, fault count that triggers lockout (1..2^CNT_W-1).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- login  in  1  open or refresh session (pulse or level)
- trigger  in  1  per-request bypass, sampled with req_valid
- cfg_wr_en  in  1  region write strobe
- cfg_idx  in  IDX_W  region to write
- cfg_base  in  ADDR_W  new inclusive lower bound
- cfg_limit  in  ADDR_W  new inclusive upper bound
- cfg_enable  in  1  new region enable
- req_valid  in  1  request present
- req_addr  in  ADDR_W  processor address
- resp_valid  out  1  response present
- resp_addr  out  ADDR_W  address to memory; 0 when blocked
- resp_protected  out  1  request blocked
- resp_region  out  IDX_W  lowest-index matching region; 0 if none
- session_active  out  1  FSM in SESSION
- lockout  out  1  FSM in LOCKOUT
- fault_count  out  CNT_W  saturating blocked-request count

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM = LOCKED; all response outputs 0; fault_count 0.
  - Region 0 = {DEF_LOWER, DEF_UPPER, enabled}; all other regions = {0, 0, disabled}.
- Region match: enable && base <= addr <= limit, unsigned, inclusive at both ends. base > limit never matches.
- FSM states LOCKED, SESSION, LOCKOUT:
  - LOCKED -> SESSION on login; session timer loaded with SESSION_LEN.
  - SESSION: timer decrements each cycle.
    - login reloads the timer to SESSION_LEN.
    - Timer reaching 0 with no login that cycle -> LOCKED.
  - Any state except LOCKOUT -> LOCKOUT on the cycle fault_count becomes >= MAX_FAULTS. LOCKOUT has priority over login in the same cycle.
  - LOCKOUT is exited only by reset; login is ignored in LOCKOUT.
- Block decision, evaluated on req_valid using state and regions registered before the current edge:
  - LOCKOUT: always blocked; trigger ignored.
  - SESSION, or trigger=1: never blocked.
  - LOCKED: blocked if any region matches.
- Latency: exactly 1 cycle. A request at edge N produces resp_valid=1 with addr, protected and region at edge N+1.
  - resp_valid follows req_valid; no backpressure.
  - When resp_valid=0: resp_addr, resp_protected and resp_region are 0.
- resp_region reports the lowest matching index even when the request is not blocked.
- Faults: each blocked valid request increments fault_count by 1, saturating at 2^CNT_W-1. Increments continue in LOCKOUT until saturation.
- Config writes:
  - Accepted only in SESSION; ignored in LOCKED and LOCKOUT.
  - Take effect for requests at the next edge onward; a request in the same cycle uses the old values.
  - cfg_idx >= NUM_REGIONS is ignored.
- Simultaneous login and req in LOCKED: the request is judged as LOCKED; the session opens after the edge.

Optional Feature:
- Macro MPU_FAULT_ADDR_EN.
- When defined: adds outputs fault_addr [ADDR_W] and fault_addr_valid [1], both 0 at reset.
  - On the first blocked request after reset, fault_addr captures req_addr and fault_addr_valid sets, both visible at the same edge as the response.
  - Both hold until reset; later faults do not overwrite.
- When undefined: those ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset release, LOCKED, req 8000, 8400, 8800, 7999, 8801 -> protected 1,1,1,0,0 one cycle later; resp_addr 0,0,0,7999,8801; fault_count=3.
- LOCKED, req 8400 with trigger=1 -> protected 0, resp_addr 8400, fault_count unchanged.
- login pulse, then req 8400 for 16 cycles -> unblocked. Cycle 17 after login -> session_active=0 and req 8400 blocked. login at cycle 10 extends the session to cycle 26.
- In SESSION write region 2 = {0x100, 0x1FF, en}. Expire the session, then req 0x100 -> protected 1, resp_region 2. Req 0x200 -> protected 0. A cfg write in LOCKED to region 2 has no effect.
- 4 blocked requests -> lockout=1 the edge after the 4th response; subsequent login and trigger=1 req 8400 stay blocked; assert reset mid-stream -> all outputs 0 immediately, region 0 reverts to 8000..8800.
- MPU_FAULT_ADDR_EN: blocked 8100 then blocked 8200 -> fault_addr=8100, fault_addr_valid=1; both cleared by reset.
